sdram_cmd_arbiter: RTL and testbench

//   Owns the SDRAM command/address pins. Arbitrates between the read engine, the write

---
 rtl/sdram_cmd_arbiter_pkg.sv | 33 +++
 rtl/sdram_cmd_arbiter_if.sv | 41 ++++
 rtl/sdram_cmd_arbiter_refresh_timer.sv | 48 ++++
 rtl/sdram_cmd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared definitions for the SDRAM command arbiter: pin command encodings,
// timing defaults, bus widths and the arbiter state encoding.
package sdram_cmd_arbiter_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned A10    = 10;

  localparam int unsigned REF_INTERVAL_DEF = 780;
  localparam int unsigned T_RP_DEF         = 2;
  localparam int unsigned T_RFC_DEF        = 7;
  localparam int unsigned REF_MAX_PEND_DEF = 3;

  // {we_n, cas_n, ras_n}
  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'b111,
    CMD_ACT   = 3'b110,
    CMD_READ  = 3'b101,
    CMD_WRITE = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_REF   = 3'b100
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT_RD,
    ST_GRANT_WR,
    ST_REF_PRE,
    ST_REF_CMD
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Handshake and pin bundle around the SDRAM command arbiter.
// master: front end + read/write engines side; slave: the arbiter.
interface sdram_cmd_arbiter_if;
  import sdram_cmd_arbiter_pkg::*;

  logic              init_done;
  logic              rd_req;
  logic              wr_req;
  logic              rd_ack;
  logic              wr_ack;
  logic              rd_en;
  logic              wr_en;
  logic              rd_finished;
  logic              wr_finished;
  logic [CMD_W-1:0]  rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic [CMD_W-1:0]  wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic [CMD_W-1:0]  sd_cmd;
  logic [ADDR_W-1:0] sd_addr;
  logic [BANK_W-1:0] sd_bank;
  logic              busy;
  logic              ref_overflow;

  modport master (
    output init_done, rd_req, wr_req, rd_finished, wr_finished,
           rd_cmd, rd_addr, rd_bank, wr_cmd, wr_addr, wr_bank,
    input  rd_ack, wr_ack, rd_en, wr_en, sd_cmd, sd_addr, sd_bank,
           busy, ref_overflow
  );

  modport slave (
    input  init_done, rd_req, wr_req, rd_finished, wr_finished,
           rd_cmd, rd_addr, rd_bank, wr_cmd, wr_addr, wr_bank,
    output rd_ack, wr_ack, rd_en, wr_en, sd_cmd, sd_addr, sd_bank,
           busy, ref_overflow
  );

endinterface

// File: rtl/sdram_cmd_arbiter_refresh_timer.sv
// Refresh interval counter, saturating pending-refresh counter and sticky
// overflow flag. A wrap and a serviced refresh on the same cycle cancel.
module sdram_cmd_arbiter_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned REF_MAX_PEND = 3,
  parameter int unsigned PEND_W       = $clog2(REF_MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dec,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [PEND_W-1:0] MAX  = PEND_W'(REF_MAX_PEND);

  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend_nxt;
  logic              tick;

  // Wrap detection and next pending count with saturation at both ends
  always_comb begin
    tick     = en && (cnt == LAST);
    pend_nxt = pending;
    if (tick && !dec) begin
      if (pending != MAX) pend_nxt = pending + 1'b1;
    end else if (dec && !tick) begin
      if (pending != '0) pend_nxt = pending - 1'b1;
    end
  end

  // Interval counter, pending counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      pending <= pend_nxt;
      if (pend_nxt == MAX) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command/address pin owner: arbitrates read engine, write engine and
// auto-refresh, and drives the granted source onto the pins (registered).
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN: alternate read/write on a
// tie; otherwise read wins every tie.
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int unsigned T_RP         = T_RP_DEF,
  parameter int unsigned T_RFC        = T_RFC_DEF,
  parameter int unsigned REF_MAX_PEND = REF_MAX_PEND_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sdram_cmd_arbiter_if.slave bus
);

  localparam int unsigned PEND_W  = $clog2(REF_MAX_PEND + 1);
  localparam int unsigned DLY_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

  arb_state_e        state, state_nxt;
  logic [DLY_W-1:0]  dly, dly_nxt;
  logic [CMD_W-1:0]  cmd_q, cmd_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [BANK_W-1:0] bank_q, bank_nxt;
  logic              rd_pulse, wr_pulse;
  logic              rd_go, wr_go;
  logic              rd_win, wr_win;
  logic              ref_dec;
  logic [PEND_W-1:0] pending;
  logic              overflow;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic              last_wr;
`endif

  sdram_cmd_arbiter_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_MAX_PEND (REF_MAX_PEND),
    .PEND_W       (PEND_W)
  ) u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.init_done),
    .dec      (ref_dec),
    .pending  (pending),
    .overflow (overflow)
  );

  // Resolve simultaneous read/write requests into a single winner
  always_comb begin
    rd_win = 1'b0;
    wr_win = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    if (bus.rd_req && bus.wr_req) begin
      rd_win = last_wr;
      wr_win = !last_wr;
    end else begin
      rd_win = bus.rd_req;
      wr_win = bus.wr_req;
    end
`else
    rd_win = bus.rd_req;
    wr_win = bus.wr_req && !bus.rd_req;
`endif
  end

  // Next state and next registered pin values; NOP unless a command is due
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    cmd_nxt   = CMD_NOP;
    addr_nxt  = '0;
    bank_nxt  = '0;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    ref_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.init_done) begin
          if (pending != '0) begin
            state_nxt     = ST_REF_PRE;
            cmd_nxt       = CMD_PRE;
            addr_nxt[A10] = 1'b1;
            dly_nxt       = DLY_W'(T_RP);
          end else if (rd_win) begin
            state_nxt = ST_GRANT_RD;
            rd_go     = 1'b1;
          end else if (wr_win) begin
            state_nxt = ST_GRANT_WR;
            wr_go     = 1'b1;
          end
        end
      end
      ST_GRANT_RD: begin
        if (bus.rd_finished) begin
          state_nxt = ST_IDLE;
        end else begin
          cmd_nxt  = bus.rd_cmd;
          addr_nxt = bus.rd_addr;
          bank_nxt = bus.rd_bank;
        end
      end
      ST_GRANT_WR: begin
        if (bus.wr_finished) begin
          state_nxt = ST_IDLE;
        end else begin
          cmd_nxt  = bus.wr_cmd;
          addr_nxt = bus.wr_addr;
          bank_nxt = bus.wr_bank;
        end
      end
      ST_REF_PRE: begin
        if (dly == '0) begin
          state_nxt = ST_REF_CMD;
          cmd_nxt   = CMD_REF;
          ref_dec   = 1'b1;
          dly_nxt   = DLY_W'(T_RFC);
        end else begin
          dly_nxt = dly - 1'b1;
        end
      end
      ST_REF_CMD: begin
        if (dly == '0) state_nxt = ST_IDLE;
        else           dly_nxt   = dly - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, delay counter, pin registers and grant pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dly      <= '0;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
      bank_q   <= '0;
      rd_pulse <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly      <= dly_nxt;
      cmd_q    <= cmd_nxt;
      addr_q   <= addr_nxt;
      bank_q   <= bank_nxt;
      rd_pulse <= rd_go;
      wr_pulse <= wr_go;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Remember the last granted side; resets to write so the first tie reads
  always_ff @(posedge clk) begin
    if (rst)        last_wr <= 1'b1;
    else if (rd_go) last_wr <= 1'b0;
    else if (wr_go) last_wr <= 1'b1;
  end
`endif

  assign bus.sd_cmd       = cmd_q;
  assign bus.sd_addr      = addr_q;
  assign bus.sd_bank      = bank_q;
  assign bus.rd_ack       = rd_pulse;
  assign bus.rd_en        = rd_pulse;
  assign bus.wr_ack       = wr_pulse;
  assign bus.wr_en        = wr_pulse;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.ref_overflow = overflow;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Randomized bench for sdram_cmd_arbiter against an operation-level model.
module tb_sdram_cmd_arbiter;
  import sdram_cmd_arbiter_pkg::*;

  localparam int unsigned RI   = 780;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRFC = 7;
  localparam int unsigned PMAX = 3;
  localparam int unsigned REF_LEN = 2 + TRP + TRFC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_cmd_arbiter_if bus();

  sdram_cmd_arbiter #(
    .REF_INTERVAL (RI),
    .T_RP         (TRP),
    .T_RFC        (TRFC),
    .REF_MAX_PEND (PMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operation in progress plus refresh bookkeeping
  int unsigned n_init;
  int          pend;
  bit          ovf;
  int          mode;     // 0 idle, 1 refresh sequence, 2 read burst, 3 write burst
  int          ref_pos;
  bit          last_wr;
  logic [2:0]  e_cmd;
  logic [11:0] e_addr;
  logic [1:0]  e_bank;
  bit          e_busy;
  logic [3:0]  e_pulse;  // {rd_ack, rd_en, wr_ack, wr_en}

  // Stimulus state
  bit          allow_req, tie_mode, allow_spur;
  int          rd_rem, wr_rem, force_len;
  int          tie_log[$];

  function automatic logic [2:0] ref_cmd_at(input int k);
    if (k == 0) return CMD_PRE;
    if (k == 1 + TRP) return CMD_REF;
    return CMD_NOP;
  endfunction

  task automatic grant(input bit is_wr);
    mode    = is_wr ? 3 : 2;
    e_pulse = is_wr ? 4'b0011 : 4'b1100;
    last_wr = is_wr;
  endtask

  task automatic model_edge();
    bit tick, dec;
    if (rst) begin
      mode = 0; pend = 0; ovf = 0; n_init = 0; last_wr = 1;
      e_cmd = CMD_NOP; e_addr = '0; e_bank = '0; e_busy = 0; e_pulse = '0;
      return;
    end
    tick = bus.init_done && (n_init % RI == RI - 1);
    if (bus.init_done) n_init++;
    dec = 0; e_pulse = '0; e_cmd = CMD_NOP; e_addr = '0; e_bank = '0;
    case (mode)
      0: if (bus.init_done) begin
        if (pend > 0) begin
          mode = 1; ref_pos = 0; e_cmd = CMD_PRE; e_addr = 12'h400;
        end else if (bus.rd_req && bus.wr_req) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          grant(!last_wr);
`else
          grant(1'b0);
`endif
        end else if (bus.rd_req) grant(1'b0);
        else if (bus.wr_req) grant(1'b1);
      end
      1: begin
        ref_pos++;
        if (ref_pos == REF_LEN) mode = 0;
        else e_cmd = ref_cmd_at(ref_pos);
        if (ref_pos == 1 + TRP) dec = 1;
      end
      2: if (bus.rd_finished) mode = 0;
         else begin e_cmd = bus.rd_cmd; e_addr = bus.rd_addr; e_bank = bus.rd_bank; end
      3: if (bus.wr_finished) mode = 0;
         else begin e_cmd = bus.wr_cmd; e_addr = bus.wr_addr; e_bank = bus.wr_bank; end
      default: mode = 0;
    endcase
    pend = pend + int'(tick) - int'(dec);
    if (pend > PMAX) pend = PMAX;
    if (pend == PMAX) ovf = 1;
    e_busy = (mode != 0);
  endtask

  function automatic int pick_len();
    int l;
    if (force_len != 0) begin l = force_len; force_len = 0; return l; end
    if (tie_mode) return 4;
    if ($urandom_range(0, 15) == 0) return 100;
    return $urandom_range(1, 24);
  endfunction

  task automatic clear_stim();
    bus.rd_req = 0; bus.wr_req = 0; bus.rd_finished = 0; bus.wr_finished = 0;
    rd_rem = 0; wr_rem = 0;
  endtask

  task automatic drive();
    if (rst) begin clear_stim(); return; end
    if (bus.rd_ack) begin bus.rd_req = 0; if (tie_mode) tie_log.push_back(0); end
    if (bus.wr_ack) begin bus.wr_req = 0; if (tie_mode) tie_log.push_back(1); end
    if (tie_mode) begin
      bus.rd_req = 1; bus.wr_req = 1;
    end else if (allow_req) begin
      if (!bus.rd_req && $urandom_range(0, 5) == 0) bus.rd_req = 1;
      if (!bus.wr_req && $urandom_range(0, 5) == 0) bus.wr_req = 1;
    end
    if (bus.rd_en) rd_rem = pick_len();
    if (rd_rem > 0) begin rd_rem--; bus.rd_finished = (rd_rem == 0); end
    else bus.rd_finished = allow_spur && ($urandom_range(0, 40) == 0);
    if (bus.wr_en) wr_rem = pick_len();
    if (wr_rem > 0) begin wr_rem--; bus.wr_finished = (wr_rem == 0); end
    else bus.wr_finished = allow_spur && ($urandom_range(0, 40) == 0);
    bus.rd_cmd = 3'($urandom); bus.rd_addr = 12'($urandom); bus.rd_bank = 2'($urandom);
    bus.wr_cmd = 3'($urandom); bus.wr_addr = 12'($urandom); bus.wr_bank = 2'($urandom);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sd_cmd", bus.sd_cmd, e_cmd);
    check_eq("sd_addr", bus.sd_addr, e_addr);
    check_eq("sd_bank", bus.sd_bank, e_bank);
    check_eq("busy", bus.busy, e_busy);
    check_eq("ack_en", {bus.rd_ack, bus.rd_en, bus.wr_ack, bus.wr_en}, e_pulse);
    check_eq("ref_overflow", bus.ref_overflow, ovf);
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int k;
    int exp_tie[4];
    rst = 1; bus.init_done = 0;
    allow_req = 0; tie_mode = 0; allow_spur = 0; force_len = 0;
    clear_stim();
    bus.rd_cmd = '1; bus.rd_addr = '0; bus.rd_bank = '0;
    bus.wr_cmd = '1; bus.wr_addr = '0; bus.wr_bank = '0;
    run(3);
    check_eq("reset_cmd", bus.sd_cmd, 3'b111);
    check_eq("reset_busy", bus.busy, 1'b0);
    rst = 0;

    // Requests before init_done must not be granted
    allow_req = 1; allow_spur = 1;
    run(30);
    bus.init_done = 1;
    run(6000);

    // Long read burst across several refresh intervals
    allow_req = 0;
    k = 0;
    while (k < 600 && !(mode == 0 && !bus.rd_req && !bus.wr_req && rd_rem == 0 && wr_rem == 0)) begin
      cycle(); k++;
    end
    check_eq("drain_wait", (mode == 0 && !bus.rd_req && !bus.wr_req) ? 1 : 0, 1);
    force_len = 4 * RI + 20;
    bus.rd_req = 1;
    run(5);
    k = 0;
    while (k < 4 * RI + 300 && mode != 0) begin cycle(); k++; end
    check_eq("long_burst_done", mode, 0);
    check_eq("overflow_set", bus.ref_overflow, 1'b1);
    allow_req = 1;
    run(1500);
    check_eq("overflow_sticky", bus.ref_overflow, 1'b1);

    // Reset right after REF is issued
    k = 0;
    while (k < 2000 && !(mode == 1 && ref_pos == 1 + TRP)) begin cycle(); k++; end
    check_eq("refresh_seen", (mode == 1) ? 1 : 0, 1);
    rst = 1;
    clear_stim();
    cycle();
    check_eq("midref_rst_cmd", bus.sd_cmd, 3'b111);
    check_eq("midref_rst_busy", bus.busy, 1'b0);
    check_eq("midref_rst_ovf", bus.ref_overflow, 1'b0);
    rst = 0;
    run(800);

    // Both requests held high: grant order on ties
    rst = 1; clear_stim(); allow_req = 0; allow_spur = 0;
    run(2);
    rst = 0;
    tie_mode = 1;
    tie_log.delete();
    k = 0;
    while (k < 200 && tie_log.size() < 4) begin cycle(); k++; end
    tie_mode = 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_tie = '{0, 1, 0, 1};
`else
    exp_tie = '{0, 0, 0, 0};
`endif
    check_eq("tie_count", tie_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("tie_grant%0d", i), (i < tie_log.size()) ? tie_log[i] : 9, exp_tie[i]);
    bus.rd_req = 0; bus.wr_req = 0;
    run(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
